// File: rtl/mem_access_unit.sv
// Byte-organised memory with a sequenced big-endian byte/halfword/word access engine.
// Latency: MOC rises N*(WAIT_CYCLES+1)+1 edges after MOV is sampled; 1 edge on misalignment.
// Backpressure: MOC is held while MOV stays high; a new request needs MOV low for one edge.
module mem_access_unit #(
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              MOV,
    input  logic              RW,
    input  logic [1:0]        typeData,
    input  logic [31:0]       Address,
    input  logic [31:0]       DataIn,
    input  logic              LdEn,
    input  logic [ADDR_W-1:0] LdAddr,
    input  logic [7:0]        LdByte,
    output logic [31:0]       DataOut,
    output logic              MOC,
    output logic              Busy,
    output logic              AlignErr
);

    // Wait counter must be at least one bit wide even when no wait states are used.
    localparam int WCW = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam logic [WCW-1:0] WAIT_LD = WCW'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic [7:0]        r_mem [DEPTH];
    logic [ADDR_W-1:0] r_ptr;
    logic [WCW-1:0]    r_wait;
    logic [2:0]        r_cnt;
    logic              r_rw;
    logic [31:0]       r_wdat;   // write bytes, next byte always in [31:24]
    logic [31:0]       r_asm;    // read assembly, bytes shifted in from the right

    logic              w_misalign;
    logic              w_xfer;
    logic              w_last;
    logic [7:0]        w_rbyte;
    logic [31:0]       w_asm_nxt;

    // Halfwords need an even address, words a 4-byte aligned address (11 aliases word).
    assign w_misalign = ((typeData == 2'b01) && Address[0]) ||
                        (typeData[1] && (Address[1:0] != 2'b00));
    assign w_xfer     = (r_state == S_ACCESS) && (r_wait == '0);
    assign w_last     = w_xfer && (r_cnt == 3'd1);
    assign w_rbyte    = r_mem[r_ptr];
    assign w_asm_nxt  = {r_asm[23:0], w_rbyte};
    assign Busy       = (r_state != S_IDLE);

    // State register.
    always_ff @(posedge CLK) begin
        if (CLR) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (MOV) w_next = w_misalign ? S_DONE : S_ACCESS;
            end
            S_ACCESS: begin
                if (w_last) w_next = S_DONE;
            end
            S_DONE: begin
                if (!MOV) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Request latching, wait/byte sequencing, read assembly and handshake outputs.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_ptr    <= '0;
            r_wait   <= '0;
            r_cnt    <= '0;
            r_rw     <= 1'b0;
            r_wdat   <= '0;
            r_asm    <= '0;
            DataOut  <= '0;
            MOC      <= 1'b0;
            AlignErr <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (MOV) begin
                        r_rw   <= RW;
                        r_ptr  <= Address[ADDR_W-1:0];
                        r_wait <= WAIT_LD;
                        r_asm  <= '0;
                        case (typeData)
                            2'b00: begin
                                r_cnt  <= 3'd1;
                                r_wdat <= {DataIn[7:0], 24'h0};
                            end
                            2'b01: begin
                                r_cnt  <= 3'd2;
                                r_wdat <= {DataIn[15:0], 16'h0};
                            end
                            default: begin
                                r_cnt  <= 3'd4;
                                r_wdat <= DataIn;
                            end
                        endcase
                        if (w_misalign) begin
                            AlignErr <= 1'b1;
                            MOC      <= 1'b1;
                        end else begin
                            AlignErr <= 1'b0;
                        end
                    end
                end
                S_ACCESS: begin
                    if (r_wait != '0) begin
                        r_wait <= r_wait - WCW'(1);
                    end else begin
                        r_ptr  <= r_ptr + ADDR_W'(1);
                        r_cnt  <= r_cnt - 3'd1;
                        r_wait <= WAIT_LD;
                        r_wdat <= {r_wdat[23:0], 8'h0};
                        r_asm  <= w_asm_nxt;
                        if (r_cnt == 3'd1) begin
                            MOC <= 1'b1;
                            if (r_rw) DataOut <= w_asm_nxt;
                        end
                    end
                end
                S_DONE: begin
                    if (!MOV) MOC <= 1'b0;
                end
                default: begin
                    MOC <= 1'b0;
                end
            endcase
        end
    end

    // Memory array: engine writes in ACCESS, backdoor writes in IDLE; never cleared by reset.
    always_ff @(posedge CLK) begin
        if (!CLR) begin
            if (w_xfer && !r_rw) begin
                r_mem[r_ptr] <= r_wdat[31:24];
            end else if ((r_state == S_IDLE) && !MOV && LdEn) begin
                r_mem[LdAddr] <= LdByte;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a byte-array model predicts read data, AlignErr and latency.
// Latency: each request is followed until MOC, bounded by a cycle budget.
// Backpressure: MOV is held past MOC on demand, then dropped to return the DUT to IDLE.
module tb_mem_access_unit;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;
    localparam int WAIT   = 2;

    logic              CLK = 1'b0;
    logic              CLR = 1'b1;
    logic              MOV = 1'b0;
    logic              RW  = 1'b0;
    logic [1:0]        typeData = 2'b00;
    logic [31:0]       Address  = '0;
    logic [31:0]       DataIn   = '0;
    logic              LdEn     = 1'b0;
    logic [ADDR_W-1:0] LdAddr   = '0;
    logic [7:0]        LdByte   = '0;
    logic [31:0]       DataOut;
    logic              MOC;
    logic              Busy;
    logic              AlignErr;

    mem_access_unit #(
        .ADDR_W      (ADDR_W),
        .DEPTH       (DEPTH),
        .WAIT_CYCLES (WAIT)
    ) dut (
        .CLK      (CLK),
        .CLR      (CLR),
        .MOV      (MOV),
        .RW       (RW),
        .typeData (typeData),
        .Address  (Address),
        .DataIn   (DataIn),
        .LdEn     (LdEn),
        .LdAddr   (LdAddr),
        .LdByte   (LdByte),
        .DataOut  (DataOut),
        .MOC      (MOC),
        .Busy     (Busy),
        .AlignErr (AlignErr)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] dat;
        logic        aerr;
        int          lat;
        int          busy;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  mdl_mem [DEPTH];
    logic [31:0] last_dout = '0;
    int          n_checks  = 0;
    int          n_fail    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic bd_load(input logic [ADDR_W-1:0] a, input logic [7:0] b);
        LdEn   = 1'b1;
        LdAddr = a;
        LdByte = b;
        tick();
        LdEn   = 1'b0;
        mdl_mem[a] = b;
    endtask

    // Issue one request; the model result goes on the scoreboard and is popped when MOC rises.
    task automatic op(input string tag, input logic rw, input logic [1:0] ty,
                      input logic [31:0] addr, input logic [31:0] din, input int hold);
        exp_t        e;
        exp_t        g;
        int          n;
        int          edges;
        int          busy_cnt;
        logic        mis;
        logic        seen;
        logic [7:0]  a;
        logic [31:0] wd;
        logic [31:0] rd;
        n   = (ty == 2'b00) ? 1 : (ty == 2'b01) ? 2 : 4;
        mis = ((ty == 2'b01) && addr[0]) || (ty[1] && (addr[1:0] != 2'b00));
        a   = addr[7:0];
        rd  = '0;
        wd  = din << (8 * (4 - n));
        if (!mis) begin
            for (int i = 0; i < n; i++) begin
                if (rw) rd = {rd[23:0], mdl_mem[a + 8'(i)]};
                else    mdl_mem[a + 8'(i)] = wd[31 - 8*i -: 8];
            end
        end
        e.dat  = (!mis && rw) ? rd : last_dout;
        e.aerr = mis;
        e.lat  = mis ? 1 : n * (WAIT + 1) + 1;
        e.busy = mis ? 0 : n * (WAIT + 1);
        sb.push_back(e);

        MOV = 1'b1; RW = rw; typeData = ty; Address = addr; DataIn = din;
        edges = 0; busy_cnt = 0; seen = 1'b0;
        while (edges < 200 && !seen) begin
            tick();
            edges++;
            if (edges == 1) begin
                // Latched inputs must no longer matter; a backdoor load outside IDLE is ignored.
                RW = ~rw; typeData = ~ty; Address = ~addr; DataIn = ~din;
                LdEn = 1'b1; LdAddr = 8'h80; LdByte = 8'h55;
            end
            if (MOC) seen = 1'b1;
            else if (Busy) busy_cnt++;
        end
        check({tag, "_moc_seen"}, 32'(seen), 32'd1);
        g = sb.pop_front();
        check({tag, "_latency"}, edges, g.lat);
        check({tag, "_busy_cycles"}, busy_cnt, g.busy);
        check({tag, "_dataout"}, DataOut, g.dat);
        check({tag, "_alignerr"}, 32'(AlignErr), 32'(g.aerr));
        for (int h = 0; h < hold; h++) begin
            tick();
            check({tag, "_hold_moc"}, 32'(MOC), 32'd1);
            check({tag, "_hold_dataout"}, DataOut, g.dat);
        end
        MOV = 1'b0; LdEn = 1'b0;
        tick();
        check({tag, "_moc_drop"}, 32'(MOC), 32'd0);
        check({tag, "_idle_busy"}, 32'(Busy), 32'd0);
        check({tag, "_dataout_held"}, DataOut, g.dat);
        last_dout = g.dat;
    endtask

    initial begin
        logic moc_during_clr;
        for (int i = 0; i < DEPTH; i++) mdl_mem[i] = 8'h00;

        tick();
        tick();
        CLR = 1'b0;
        check("rst_dataout", DataOut, 32'h0);
        check("rst_moc", 32'(MOC), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_alignerr", 32'(AlignErr), 32'd0);

        bd_load(8'h10, 8'hDE); bd_load(8'h11, 8'hAD);
        bd_load(8'h12, 8'hBE); bd_load(8'h13, 8'hEF);
        for (int i = 0; i < 4; i++) bd_load(8'h40 + 8'(i), 8'h00);
        bd_load(8'h80, 8'h00);
        bd_load(8'hF0, 8'h11); bd_load(8'hF1, 8'h22);
        bd_load(8'hF2, 8'h33); bd_load(8'hF3, 8'h44);

        op("rd_w10", 1'b1, 2'b10, 32'h10, 32'h0, 0);
        check("rd_w10_const", DataOut, 32'hDEADBEEF);
        op("rd_b12", 1'b1, 2'b00, 32'h12, 32'h0, 0);
        check("rd_b12_const", DataOut, 32'h000000BE);
        op("rd_h12", 1'b1, 2'b01, 32'h12, 32'h0, 0);
        check("rd_h12_const", DataOut, 32'h0000BEEF);

        op("wr_w20", 1'b0, 2'b10, 32'h20, 32'h12345678, 0);
        op("rd_w20", 1'b1, 2'b10, 32'h20, 32'h0, 0);
        check("rd_w20_const", DataOut, 32'h12345678);
        op("rd_b23", 1'b1, 2'b00, 32'h23, 32'h0, 0);
        check("rd_b23_const", DataOut, 32'h00000078);
        op("wr_h22", 1'b0, 2'b01, 32'h22, 32'h0000CAFE, 0);
        op("rd_w20b", 1'b1, 2'b11, 32'h20, 32'h0, 0);
        check("rd_w20b_const", DataOut, 32'h1234CAFE);

        op("mis_h11", 1'b1, 2'b01, 32'h11, 32'h0, 0);
        op("mis_w22", 1'b1, 2'b10, 32'h22, 32'h0, 0);
        op("mis_wr22", 1'b0, 2'b10, 32'h22, 32'hFFFFFFFF, 0);
        op("rd_w20c", 1'b1, 2'b10, 32'h20, 32'h0, 0);
        check("mis_mem_const", DataOut, 32'h1234CAFE);

        op("hold_w10", 1'b1, 2'b10, 32'h10, 32'h0, 10);
        op("alias_rd", 1'b1, 2'b10, 32'h1F0, 32'h0, 0);
        check("alias_rd_const", DataOut, 32'h11223344);
        op("alias_wr", 1'b0, 2'b10, 32'hABCD01F4, 32'hA5A55A5A, 0);
        op("alias_rdb", 1'b1, 2'b10, 32'hF4, 32'h0, 0);
        op("ld_ignored", 1'b1, 2'b00, 32'h80, 32'h0, 0);

        // Reset lands on the edge that would transfer the third byte of a word write.
        MOV = 1'b1; RW = 1'b0; typeData = 2'b10; Address = 32'h40; DataIn = 32'hAABBCCDD;
        moc_during_clr = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (MOC) moc_during_clr = 1'b1;
        end
        CLR = 1'b1; MOV = 1'b0;
        tick();
        CLR = 1'b0;
        check("clr_no_moc", 32'(moc_during_clr | MOC), 32'd0);
        check("clr_busy", 32'(Busy), 32'd0);
        check("clr_dataout", DataOut, 32'h0);
        check("clr_alignerr", 32'(AlignErr), 32'd0);
        mdl_mem[8'h40] = 8'hAA;
        mdl_mem[8'h41] = 8'hBB;
        last_dout = '0;
        tick();
        op("clr_rb40", 1'b1, 2'b00, 32'h40, 32'h0, 0);
        check("clr_rb40_const", DataOut, 32'h000000AA);
        op("clr_rb41", 1'b1, 2'b00, 32'h41, 32'h0, 0);
        check("clr_rb41_const", DataOut, 32'h000000BB);
        op("clr_rb42", 1'b1, 2'b00, 32'h42, 32'h0, 0);
        check("clr_rb42_const", DataOut, 32'h00000000);
        op("clr_rb43", 1'b1, 2'b00, 32'h43, 32'h0, 0);
        check("clr_rb43_const", DataOut, 32'h00000000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
